// File: rtl/i2c_target_regs.sv
// i2c_target_regs
// I2C target answering one 7-bit address. It exposes a bank of 8-bit
// registers to an external I2C controller and to local system logic.
// SCL is never driven. SDA is open-drain: the pad output is tied low and
// the enable decides whether the line is pulled low or released.
//
// Ports:
//   clk            system clock, at least 20x the SCL rate
//   axi_reset_n    asynchronous active-low reset
//   scl_pad_i      SCL line input
//   sda_pad_i      SDA line input
//   sda_pad_o      SDA pad output, constant 0
//   sda_padoen_o   SDA output enable, active low (0 pulls SDA low)
//   loc_we         local write strobe
//   loc_addr       local register index
//   loc_wdata      local write data
//   loc_rdata      combinational read of reg[loc_addr]
//   i2c_wr_valid   one-cycle pulse when an I2C data byte is committed
//   i2c_wr_addr    index of the committed byte
//   i2c_wr_data    value of the committed byte
//   busy           high from an address match until STOP
//
// state        | meaning
// ST_IDLE      | SDA released, waiting for START
// ST_ADDR      | shifting in address + R/W
// ST_ADDR_ACK  | acknowledging address
// ST_PTR       | shifting in register pointer
// ST_PTR_ACK   | acknowledging pointer
// ST_WDATA     | shifting in write data
// ST_WDATA_ACK | acknowledging write data
// ST_RDATA     | driving read data, MSB first
// ST_RDATA_ACK | sampling controller ACK/NACK

module i2c_target_regs #(
    parameter logic [6:0] I2C_ADDR = 7'h50,
    parameter int         NUM_REGS = 16,
    parameter int         PTR_W    = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             axi_reset_n,
    input  logic             scl_pad_i,
    input  logic             sda_pad_i,
    output logic             sda_pad_o,
    output logic             sda_padoen_o,
    input  logic             loc_we,
    input  logic [PTR_W-1:0] loc_addr,
    input  logic [7:0]       loc_wdata,
    output logic [7:0]       loc_rdata,
    output logic             i2c_wr_valid,
    output logic [PTR_W-1:0] i2c_wr_addr,
    output logic [7:0]       i2c_wr_data,
    output logic             busy
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } state_t;

    state_t           state;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic [PTR_W-1:0] ptr;
    logic             rw;
    logic             ack_drv;
    logic [7:0]       regs [NUM_REGS];

    logic [1:0] scl_sync, sda_sync;
    logic [2:0] scl_hist, sda_hist;
    logic       scl_f, sda_f, scl_q, sda_q;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    // Idle bus is high, so the conditioning chain resets to 1 to avoid a
    // false START/STOP straight out of reset.
    always_ff @(posedge clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= '1;
            sda_hist <= '1;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_pad_i};
            sda_sync <= {sda_sync[0], sda_pad_i};
            scl_hist <= {scl_hist[1:0], scl_sync[1]};
            sda_hist <= {sda_hist[1:0], sda_sync[1]};
            scl_f    <= maj3(scl_hist);
            sda_f    <= maj3(sda_hist);
            scl_q    <= scl_f;
            sda_q    <= sda_f;
        end
    end

    logic             scl_rise, scl_fall, start_det, stop_det, last_bit, commit;
    logic [7:0]       rx_byte;
    logic [PTR_W-1:0] ptr_inc;

    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;
    assign start_det = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
    assign rx_byte   = {shift[6:0], sda_f};
    assign last_bit  = (bit_cnt == 3'd7);
    assign ptr_inc   = ptr + PTR_W'(1);
    // START/STOP need SCL stable high, so they never coincide with a rise.
    assign commit    = (state == ST_WDATA) & scl_rise & last_bit;

    assign sda_pad_o = 1'b0;
    assign loc_rdata = regs[loc_addr];

    // The I2C commit is assigned last so it wins a same-register collision.
    always_ff @(posedge clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else begin
            if (loc_we) regs[loc_addr] <= loc_wdata;
            if (commit) regs[ptr] <= rx_byte;
        end
    end

    always_ff @(posedge clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state        <= ST_IDLE;
            bit_cnt      <= 3'd0;
            shift        <= 8'h00;
            ptr          <= '0;
            rw           <= 1'b0;
            ack_drv      <= 1'b0;
            sda_padoen_o <= 1'b1;
            i2c_wr_valid <= 1'b0;
            i2c_wr_addr  <= '0;
            i2c_wr_data  <= 8'h00;
            busy         <= 1'b0;
        end else begin
            i2c_wr_valid <= 1'b0;
            if (start_det) begin
                state        <= ST_ADDR;
                bit_cnt      <= 3'd0;
                ack_drv      <= 1'b0;
                sda_padoen_o <= 1'b1;
            end else if (stop_det) begin
                state        <= ST_IDLE;
                busy         <= 1'b0;
                ack_drv      <= 1'b0;
                sda_padoen_o <= 1'b1;
            end else begin
                case (state)
                    ST_ADDR: if (scl_rise) begin
                        shift   <= rx_byte;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit) begin
                            if (rx_byte[7:1] == I2C_ADDR) begin
                                state <= ST_ADDR_ACK;
                                busy  <= 1'b1;
                                rw    <= rx_byte[0];
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                    ST_PTR: if (scl_rise) begin
                        shift   <= rx_byte;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit) begin
                            ptr   <= rx_byte[PTR_W-1:0];
                            state <= ST_PTR_ACK;
                        end
                    end
                    ST_WDATA: if (scl_rise) begin
                        shift   <= rx_byte;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit) begin
                            i2c_wr_valid <= 1'b1;
                            i2c_wr_addr  <= ptr;
                            i2c_wr_data  <= rx_byte;
                            ptr          <= ptr_inc;
                            state        <= ST_WDATA_ACK;
                        end
                    end
                    // First fall (end of byte) pulls SDA low; the second
                    // fall (end of ACK clock) releases it and moves on.
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
                        if (!ack_drv) begin
                            sda_padoen_o <= 1'b0;
                            ack_drv      <= 1'b1;
                        end else begin
                            sda_padoen_o <= 1'b1;
                            ack_drv      <= 1'b0;
                            bit_cnt      <= 3'd0;
                            if (state == ST_ADDR_ACK && rw) begin
                                // Read MSB goes out on this same fall.
                                shift        <= {regs[ptr][6:0], 1'b1};
                                sda_padoen_o <= regs[ptr][7];
                                state        <= ST_RDATA;
                            end else if (state == ST_ADDR_ACK) begin
                                state <= ST_PTR;
                            end else begin
                                state <= ST_WDATA;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (last_bit) state <= ST_RDATA_ACK;
                        end else if (scl_fall) begin
                            sda_padoen_o <= shift[7];
                            shift        <= {shift[6:0], 1'b1};
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (scl_fall) begin
                            sda_padoen_o <= 1'b1;
                        end else if (scl_rise) begin
                            ptr <= ptr_inc;
                            if (!sda_f) begin
                                shift   <= regs[ptr_inc];
                                bit_cnt <= 3'd0;
                                state   <= ST_RDATA;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a bit-banged I2C controller drives the
// bus; SDA is modelled as a wired-AND of controller and target.
module tb_i2c_target_regs;
    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ctrl_scl, ctrl_sda, glitch;
    logic       scl_pad_i, sda_pad_i;
    logic       sda_pad_o, sda_padoen_o;
    logic       loc_we;
    logic [3:0] loc_addr;
    logic [7:0] loc_wdata, loc_rdata;
    logic       i2c_wr_valid;
    logic [3:0] i2c_wr_addr;
    logic [7:0] i2c_wr_data;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [3:0] wr_a [$];
    logic [7:0] wr_d [$];
    logic       low_seen, busy_seen;

    always #5 clk = ~clk;

    assign scl_pad_i = ctrl_scl & ~glitch;
    assign sda_pad_i = ctrl_sda & (sda_padoen_o | sda_pad_o);

    i2c_target_regs #(.I2C_ADDR(7'h50), .NUM_REGS(16)) dut (
        .clk(clk), .axi_reset_n(rst_n),
        .scl_pad_i(scl_pad_i), .sda_pad_i(sda_pad_i),
        .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o),
        .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
        .loc_rdata(loc_rdata),
        .i2c_wr_valid(i2c_wr_valid), .i2c_wr_addr(i2c_wr_addr),
        .i2c_wr_data(i2c_wr_data), .busy(busy)
    );

    always @(negedge clk) begin
        if (i2c_wr_valid) begin
            wr_a.push_back(i2c_wr_addr);
            wr_d.push_back(i2c_wr_data);
        end
        if (!sda_padoen_o) low_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        ctrl_sda = 1'b1; wq(Q);
        ctrl_scl = 1'b1; wq(Q);
        ctrl_sda = 1'b0; wq(Q);
        ctrl_scl = 1'b0; wq(Q);
    endtask

    task automatic i2c_stop();
        ctrl_sda = 1'b0; wq(Q);
        ctrl_scl = 1'b1; wq(Q);
        ctrl_sda = 1'b1; wq(Q);
    endtask

    task automatic wbit(input logic b, input logic g);
        ctrl_sda = b; wq(Q);
        ctrl_scl = 1'b1;
        if (g) begin
            wq(Q / 2);
            glitch = 1'b1; wq(1);
            glitch = 1'b0; wq(Q + Q / 2 - 1);
        end else begin
            wq(2 * Q);
        end
        ctrl_scl = 1'b0; wq(Q);
    endtask

    task automatic rbit(output logic b);
        ctrl_sda = 1'b1; wq(Q);
        ctrl_scl = 1'b1; wq(Q);
        b = sda_pad_i; wq(Q);
        ctrl_scl = 1'b0; wq(Q);
    endtask

    task automatic wbyte(input logic [7:0] b, input int gbit, output logic ack);
        for (int i = 7; i >= 0; i--) wbit(b[i], (i == gbit));
        rbit(ack);
    endtask

    task automatic rbyte(output logic [7:0] b, input logic ack);
        logic x;
        for (int i = 7; i >= 0; i--) begin
            rbit(x);
            b[i] = x;
        end
        wbit(ack, 1'b0);
    endtask

    task automatic peek(input logic [3:0] a, output logic [7:0] d);
        loc_addr = a; #1;
        d = loc_rdata;
    endtask

    task automatic lwrite(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        loc_we = 1'b1; loc_addr = a; loc_wdata = d;
        @(negedge clk);
        loc_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst_n = 1'b0; ctrl_scl = 1'b1; ctrl_sda = 1'b1; glitch = 1'b0;
        loc_we = 1'b0; loc_addr = 4'd0; loc_wdata = 8'h00;
        wq(3);
        checks++;
        if ({sda_padoen_o, sda_pad_o, i2c_wr_valid, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctl got oen/o/valid/busy=%b exp=1000",
                     {sda_padoen_o, sda_pad_o, i2c_wr_valid, busy});
        end
        checks++;
        if ({i2c_wr_addr, i2c_wr_data} !== 12'h000) begin
            errors++;
            $display("FAIL reset_wr got addr=%h data=%h exp 0/00", i2c_wr_addr, i2c_wr_data);
        end
        rst_n = 1'b1; wq(5);
        peek(4'd0, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL reset_reg0 got=%h exp=00", d); end
        peek(4'd15, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL reset_reg15 got=%h exp=00", d); end
    endtask

    task automatic test_write();
        logic [3:0] acks;
        logic       bsy;
        logic [7:0] d;
        wr_a.delete(); wr_d.delete();
        i2c_start();
        wbyte(8'hA0, -1, acks[3]);
        wbyte(8'h03, -1, acks[2]);
        bsy = busy;
        wbyte(8'h11, -1, acks[1]);
        wbyte(8'h22, -1, acks[0]);
        i2c_stop(); wq(10);
        checks++;
        if (acks !== 4'b0000) begin errors++; $display("FAIL write_acks got=%b exp=0000", acks); end
        checks++;
        if (bsy !== 1'b1) begin errors++; $display("FAIL write_busy_mid got=%b exp=1", bsy); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_stop got=%b exp=0", busy); end
        peek(4'd3, d);
        checks++;
        if (d !== 8'h11) begin errors++; $display("FAIL write_reg3 got=%h exp=11", d); end
        peek(4'd4, d);
        checks++;
        if (d !== 8'h22) begin errors++; $display("FAIL write_reg4 got=%h exp=22", d); end
        checks++;
        if (wr_a.size() != 2) begin
            errors++; $display("FAIL write_pulses got=%0d exp=2", wr_a.size());
        end else if ({wr_a[0], wr_d[0], wr_a[1], wr_d[1]} !== 24'h3_11_4_22) begin
            errors++;
            $display("FAIL write_pulse_vals got=%h/%h %h/%h exp=3/11 4/22",
                     wr_a[0], wr_d[0], wr_a[1], wr_d[1]);
        end
    endtask

    task automatic test_read_rs();
        logic [3:0] acks;
        logic [7:0] d0, d1, d2;
        logic       oen, bsy;
        lwrite(4'd5, 8'hC3);
        lwrite(4'd6, 8'h5A);
        lwrite(4'd7, 8'h3C);
        i2c_start();
        wbyte(8'hA0, -1, acks[3]);
        wbyte(8'h05, -1, acks[2]);
        i2c_start();
        wbyte(8'hA1, -1, acks[1]);
        rbyte(d0, 1'b0);
        rbyte(d1, 1'b1);
        oen = sda_padoen_o;
        bsy = busy;
        i2c_stop(); wq(5);
        checks++;
        if (acks[3:1] !== 3'b000) begin errors++; $display("FAIL read_acks got=%b exp=000", acks[3:1]); end
        checks++;
        if (d0 !== 8'hC3) begin errors++; $display("FAIL read_byte0 got=%h exp=c3", d0); end
        checks++;
        if (d1 !== 8'h5A) begin errors++; $display("FAIL read_byte1 got=%h exp=5a", d1); end
        checks++;
        if (oen !== 1'b1) begin errors++; $display("FAIL read_release got=%b exp=1", oen); end
        checks++;
        if (bsy !== 1'b1) begin errors++; $display("FAIL read_busy_hold got=%b exp=1", bsy); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_stop got=%b exp=0", busy); end
        // Pointer should now sit at 7: a pointer-less read returns reg7.
        i2c_start();
        wbyte(8'hA1, -1, acks[0]);
        rbyte(d2, 1'b1);
        i2c_stop(); wq(5);
        checks++;
        if ({acks[0], d2} !== {1'b0, 8'h3C}) begin
            errors++; $display("FAIL read_ptr7 got ack=%b data=%h exp 0/3c", acks[0], d2);
        end
    endtask

    task automatic test_mismatch();
        logic a, b;
        logic [7:0] d;
        low_seen = 1'b0; busy_seen = 1'b0;
        wr_a.delete(); wr_d.delete();
        i2c_start();
        wbyte(8'hB0, -1, a);
        wbyte(8'h01, -1, b);
        i2c_stop(); wq(5);
        checks++;
        if ({a, b, low_seen, busy_seen} !== 4'b1100) begin
            errors++;
            $display("FAIL mismatch_bus got ack1/ack2/low/busy=%b exp=1100",
                     {a, b, low_seen, busy_seen});
        end
        peek(4'd1, d);
        checks++;
        if (d !== 8'h00 || wr_a.size() != 0) begin
            errors++; $display("FAIL mismatch_reg got reg1=%h pulses=%0d exp 00/0", d, wr_a.size());
        end
    endtask

    task automatic test_wrap();
        logic [2:0] acks;
        logic [7:0] d;
        i2c_start();
        wbyte(8'hA0, -1, acks[2]);
        wbyte(8'h0F, -1, acks[1]);
        wbyte(8'hAA, -1, acks[0]);
        wbyte(8'hBB, -1, acks[0]);
        i2c_stop(); wq(5);
        peek(4'd15, d);
        checks++;
        if (d !== 8'hAA) begin errors++; $display("FAIL wrap_reg15 got=%h exp=aa", d); end
        peek(4'd0, d);
        checks++;
        if (d !== 8'hBB) begin errors++; $display("FAIL wrap_reg0 got=%h exp=bb", d); end
    endtask

    task automatic test_collision();
        logic a;
        logic [7:0] d;
        int n;
        i2c_start();
        wbyte(8'hA0, -1, a);
        wbyte(8'h02, -1, a);
        for (int i = 7; i >= 1; i--) wbit(8'h99 >> i, 1'b0);
        // Last bit: hold a local write to reg2 until the commit pulse shows.
        ctrl_sda = 1'b1; wq(Q);
        loc_addr = 4'd2; loc_wdata = 8'h77; loc_we = 1'b1;
        ctrl_scl = 1'b1;
        n = 0;
        while (!i2c_wr_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        loc_we = 1'b0;
        checks++;
        if (n >= 40) begin errors++; $display("FAIL collision_timeout got no commit within 40 clk"); end
        wq(Q);
        ctrl_scl = 1'b0; wq(Q);
        rbit(a);
        i2c_stop(); wq(5);
        peek(4'd2, d);
        checks++;
        if ({a, d} !== {1'b0, 8'h99}) begin
            errors++; $display("FAIL collision_reg2 got ack=%b reg2=%h exp 0/99", a, d);
        end
    endtask

    task automatic test_abort();
        logic a;
        logic [7:0] d;
        wr_a.delete(); wr_d.delete();
        i2c_start();
        wbyte(8'hA0, -1, a);
        wbyte(8'h08, -1, a);
        for (int i = 0; i < 4; i++) wbit(1'b1, 1'b0);
        i2c_stop(); wq(5);
        peek(4'd8, d);
        checks++;
        if ({d, busy} !== 9'h000 || wr_a.size() != 0) begin
            errors++;
            $display("FAIL abort_nocommit got reg8=%h busy=%b pulses=%0d exp 00/0/0", d, busy, wr_a.size());
        end
        // Idle target must ignore a byte clocked without START.
        wbyte(8'hA0, -1, a);
        i2c_stop(); wq(5);
        checks++;
        if (a !== 1'b1) begin errors++; $display("FAIL abort_idle got ack=%b exp=1", a); end
    endtask

    task automatic test_glitch();
        logic [1:0] acks;
        logic a;
        logic [7:0] d;
        i2c_start();
        wbyte(8'hA0, -1, a);
        wbyte(8'h09, -1, acks[1]);
        wbyte(8'hC5, 3, acks[0]);
        i2c_stop(); wq(5);
        peek(4'd9, d);
        checks++;
        if ({acks, d} !== {2'b00, 8'hC5}) begin
            errors++; $display("FAIL glitch_reg9 got acks=%b reg9=%h exp 00/c5", acks, d);
        end
    endtask

    task automatic test_reset_ack();
        logic oen_ack, oen_rst;
        logic [7:0] d;
        i2c_start();
        for (int i = 7; i >= 0; i--) wbit(8'hA0 >> i, 1'b0);
        ctrl_sda = 1'b1; wq(Q);
        oen_ack = sda_padoen_o;
        rst_n = 1'b0; #1;
        oen_rst = sda_padoen_o;
        checks++;
        if ({oen_ack, oen_rst} !== 2'b01) begin
            errors++; $display("FAIL reset_in_ack got ack_oen=%b rst_oen=%b exp 0/1", oen_ack, oen_rst);
        end
        wq(3);
        rst_n = 1'b1;
        ctrl_scl = 1'b1; wq(Q);
        peek(4'd3, d);
        checks++;
        if ({d, busy} !== 9'h000) begin
            errors++; $display("FAIL reset_clear got reg3=%h busy=%b exp 00/0", d, busy);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_rs();
        test_mismatch();
        test_wrap();
        test_collision();
        test_abort();
        test_glitch();
        test_reset_ack();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- I2C target (slave) that answers one 7-bit address and exposes a bank of 8-bit registers to an external I2C controller. It is the opposite end of the bus from the AXI-lite-to-I2C-controller bridge.
- A local register port lets system logic read and write the bank.
- No clock stretching: SCL is never driven. Open-drain SDA only.

Parameters:
- I2C_ADDR, 7'h50, 7-bit target address this block answers.
- NUM_REGS, 16, register count; power of 2, range 2..256.
- PTR_W, $clog2(NUM_REGS), register pointer width (derived).

Ports:
- clk  in  1  system clock; must run at least 20x the SCL rate.
- axi_reset_n  in  1  asynchronous active-low reset.
- scl_pad_i  in  1  SCL line input.
- sda_pad_i  in  1  SDA line input.
- sda_pad_o  out  1  SDA output; constant 1'b0.
- sda_padoen_o  out  1  SDA output enable, active low; 0 pulls SDA low.
- loc_we  in  1  local write strobe.
- loc_addr  in  PTR_W  local register index.
- loc_wdata  in  8  local write data.
- loc_rdata  out  8  combinational read of reg[loc_addr].
- i2c_wr_valid  out  1  one-cycle pulse when an I2C data byte is committed.
- i2c_wr_addr  out  PTR_W  index of the committed byte.
- i2c_wr_data  out  8  value of the committed byte.
- busy  out  1  high from an addressed START (address match) until STOP.

Behaviour:
- Reset values:
  - all registers 8'h00, ptr 0, state IDLE;
  - sda_padoen_o 1, i2c_wr_valid 0, i2c_wr_addr 0, i2c_wr_data 0, busy 0.
  - Reset is honoured mid-transfer: SDA is released immediately.
- Input conditioning:
  - SCL and SDA each pass a 2-FF synchroniser, then a 3-sample majority filter.
  - Edges are detected on the filtered signals.
- Bus conditions:
  - START: SDA falls while SCL high. STOP: SDA rises while SCL high.
  - Both are honoured in every state. START, including a repeated START, goes to ADDR with bit counter 0. STOP goes to IDLE with busy 0.
- Bit timing:
  - Sample SDA on the SCL rising edge, MSB first.
  - Change sda_padoen_o only on the SCL falling edge, one clk after that edge is detected.
- States:
  - IDLE: SDA released; wait for START.
  - ADDR: shift 8 bits. If bits[7:1]==I2C_ADDR, go to ADDR_ACK and set busy. Otherwise go to IDLE (no ACK, ignore until next START).
  - ADDR_ACK: drive SDA low for one SCL period. If R/W=0, go to PTR. If R/W=1, load shift register with reg[ptr], then go to RDATA.
  - PTR: shift 8 bits; ptr <= byte[PTR_W-1:0] (upper bits ignored); go to PTR_ACK.
  - PTR_ACK: drive ACK, then go to WDATA.
  - WDATA: shift 8 bits; at the 8th rising edge commit reg[ptr] <= byte; go to WDATA_ACK.
    - i2c_wr_valid pulses that cycle, with i2c_wr_addr = ptr before increment and i2c_wr_data = byte.
    - ptr <= ptr+1 mod NUM_REGS.
  - WDATA_ACK: always ACK, then go to WDATA.
  - RDATA: drive MSB first; release SDA for 1 bits, pull low for 0 bits; go to RDATA_ACK.
  - RDATA_ACK: release SDA and sample the controller's bit on SCL rise.
    - ptr <= ptr+1 mod NUM_REGS.
    - ACK (0): reload shift register from the new reg[ptr], then go to RDATA.
    - NACK (1): go to IDLE with busy held until STOP.
- Wrap: ptr NUM_REGS-1 increments to 0, for reads and writes.
- Local port:
  - loc_we writes reg[loc_addr] in the same clk.
  - If loc_we and an I2C commit target the same register in the same cycle, the I2C commit wins and the local write is dropped.
  - A local write to reg[ptr] after the read shift register is loaded does not affect the byte already in flight.
- Latency: loc_rdata is combinational; a write is visible on loc_rdata the cycle after the commit.

Test Plan:
- Reset, then write: START, 0xA0, ptr 0x03, data 0x11 0x22, STOP -> ACK on all 4 bytes. reg3=0x11, reg4=0x22. Two i2c_wr_valid pulses (3/0x11, 4/0x22). busy low after STOP.
- Read with repeated START: local write reg5=0xC3, reg6=0x5A. Then START, 0xA0, ptr 0x05, Sr, 0xA1, read 2 bytes (controller ACK then NACK), STOP -> SDA carries 0xC3 then 0x5A. Final ptr=7. SDA released after the NACK.
- Address mismatch: START, 0xB0, 0x01, STOP -> SDA never driven low; no register change; busy stays 0.
- Wrap-around: write ptr 0x0F then data 0xAA 0xBB -> reg15=0xAA, reg0=0xBB.
- Collision and abort:
  - loc_we to reg2 with 0x77 in the same cycle as an I2C commit of 0x99 to reg2 -> reg2=0x99.
  - STOP after 4 bits of a data byte -> no commit, state IDLE.
  - axi_reset_n low during an ACK -> sda_padoen_o=1 immediately.
- Glitch rejection: 1-clk low pulse on SCL during a data bit -> filtered out; the byte is received correctly.
